// File: rtl/bpb_update_sched_pkg.sv
// Shared BPB scheduler definitions: geometry, write-mode and FSM encodings, queue entry type.
// No logic; imported by the scheduler, its FIFO, its interface and the bench.
package bpb_update_sched_pkg;
  localparam int DEPTH  = 8;
  localparam int ADDR   = $clog2(DEPTH);
  localparam int WIDTH  = 2;
  localparam int QDEPTH = 4;
  localparam int QADDR  = $clog2(QDEPTH);
  localparam logic [WIDTH-1:0] INIT_VAL = 2'b10;

  typedef enum logic {
    WR_MODE_CNT  = 1'b0,
    WR_MODE_LOAD = 1'b1
  } wr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR-1:0] addr;
    logic            res;
  } upd_t;
endpackage

// File: rtl/bpb_update_sched_if.sv
// CDB, DU and BPB-write signals of the update scheduler; master = scheduler side.
// Pure wiring, no latency; sched_full is the backpressure toward the CDB arbiter.
interface bpb_update_sched_if;
  import bpb_update_sched_pkg::*;

  logic             cdb_branch;
  logic [ADDR-1:0]  cdb_bpb_addr;
  logic             cdb_branch_res;
  logic             sched_full;
  logic             sched_ovf;
  logic             du_branch;
  logic [ADDR-1:0]  du_bpb_addr;
  logic             sched_du_stall;
  logic             bpb_ready;
  logic             bpb_wr_en;
  logic             bpb_wr_mode;
  logic [ADDR-1:0]  bpb_wr_addr;
  logic             bpb_wr_res;
  logic [WIDTH-1:0] bpb_wr_data;

  modport master (
    input  cdb_branch, cdb_bpb_addr, cdb_branch_res, du_branch, du_bpb_addr,
    output sched_full, sched_ovf, sched_du_stall, bpb_ready,
           bpb_wr_en, bpb_wr_mode, bpb_wr_addr, bpb_wr_res, bpb_wr_data
  );

  modport slave (
    output cdb_branch, cdb_bpb_addr, cdb_branch_res, du_branch, du_bpb_addr,
    input  sched_full, sched_ovf, sched_du_stall, bpb_ready,
           bpb_wr_en, bpb_wr_mode, bpb_wr_addr, bpb_wr_res, bpb_wr_data
  );
endinterface

// File: rtl/bpb_update_sched_fifo.sv
// QDEPTH-entry register FIFO of pending BPB updates, exposing per-slot valid/addr for lookups.
// Head visible same cycle it is written+1; push ignored when full, pop ignored when empty.
module bpb_update_sched_fifo
  import bpb_update_sched_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  upd_t                          push_dat,
  input  logic                          pop,
  output upd_t                          head_dat,
  output logic                          full,
  output logic                          empty,
  output logic [QDEPTH-1:0]             ent_vld,
  output logic [QDEPTH-1:0][ADDR-1:0]   ent_addr
);
  upd_t             mem [QDEPTH];
  logic [QADDR-1:0] rd_ptr;
  logic [QADDR-1:0] wr_ptr;
  logic [QADDR:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (QADDR+1)'(QDEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) ent_addr[i] = mem[i].addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      // push and pop never target the same slot: pop needs !empty, push needs !full
      for (int i = 0; i < QDEPTH; i++) begin
        if (do_pop && rd_ptr == QADDR'(i)) ent_vld[i] <= 1'b0;
        if (do_push && wr_ptr == QADDR'(i)) ent_vld[i] <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/bpb_update_sched.sv
// Sequences BPB writes: post-reset init sweep, then FIFO-ordered CDB branch updates, one per cycle.
// Latency 1 cycle from accept to write on an empty queue; sched_full backpressures CDB, stall holds DU.
module bpb_update_sched
  import bpb_update_sched_pkg::*;
(
  input logic              clk,
  input logic              reset,
  bpb_update_sched_if.master bus
);
  state_e                    state;
  state_e                    state_nxt;
  logic [ADDR-1:0]           init_cnt;
  logic                      ovf;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic                      hit;
  upd_t                      head;
  upd_t                      push_dat;
  logic [QDEPTH-1:0]         ent_vld;
  logic [QDEPTH-1:0][ADDR-1:0] ent_addr;
  logic                      ready;
  logic                      wr_en;
  wr_mode_e                  wr_mode;
  logic [ADDR-1:0]           wr_addr;
  logic                      wr_res;
  logic [WIDTH-1:0]          wr_data;

  assign push          = bus.cdb_branch & ~full;
  assign pop           = ready & ~empty;
  assign push_dat.addr = bus.cdb_bpb_addr;
  assign push_dat.res  = bus.cdb_branch_res;

  bpb_update_sched_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .ent_vld  (ent_vld),
    .ent_addr (ent_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      init_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      if (bus.cdb_branch && full) ovf <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    wr_en     = 1'b0;
    wr_mode   = WR_MODE_CNT;
    wr_addr   = '0;
    wr_res    = 1'b0;
    wr_data   = '0;
    unique case (state)
      ST_IDLE: state_nxt = ST_INIT;
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_mode = WR_MODE_LOAD;
        wr_addr = init_cnt;
        wr_data = INIT_VAL;
        if (init_cnt == ADDR'(DEPTH-1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ready   = 1'b1;
        wr_en   = ~empty;
        wr_addr = head.addr;
        wr_res  = head.res;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The head being written this cycle is still marked valid, so it also stalls the DU.
  always_comb begin
    hit = bus.cdb_branch && (bus.cdb_bpb_addr == bus.du_bpb_addr);
    for (int i = 0; i < QDEPTH; i++) begin
      if (ent_vld[i] && ent_addr[i] == bus.du_bpb_addr) hit = 1'b1;
    end
  end

  assign bus.sched_full     = full;
  assign bus.sched_ovf      = ovf;
  assign bus.sched_du_stall = ~ready | (bus.du_branch & hit);
  assign bus.bpb_ready      = ready;
  assign bus.bpb_wr_en      = wr_en;
  assign bus.bpb_wr_mode    = wr_mode;
  assign bus.bpb_wr_addr    = wr_addr;
  assign bus.bpb_wr_res     = wr_res;
  assign bus.bpb_wr_data    = wr_data;
endmodule

// File: tb/tb_bpb_update_sched.sv
// Bench for bpb_update_sched: queue-based reference model, randomized DU lookups and CDB traffic.
module tb_bpb_update_sched;
  import bpb_update_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bpb_update_sched_if bus();
  bpb_update_sched dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: cycles since reset release, pending-update queue, sticky overflow.
  upd_t mq[$];
  int   m_cyc;
  bit   m_ovf;

  function automatic void model_reset();
    m_cyc = 0;
    mq.delete();
    m_ovf = 1'b0;
  endfunction

  // Vector layout: {en, mode, addr[3], res, data[2], ready, full, ovf, stall}
  function automatic logic [12:0] exp_vec();
    logic en, mode, res, ready, hit, full, stall;
    logic [ADDR-1:0]  a;
    logic [WIDTH-1:0] d;
    en = 1'b0; mode = 1'b0; res = 1'b0; a = '0; d = '0;
    ready = (m_cyc > DEPTH);
    if (m_cyc >= 1 && m_cyc <= DEPTH) begin
      en = 1'b1; mode = 1'b1; a = ADDR'(m_cyc - 1); d = INIT_VAL;
    end else if (ready && mq.size() != 0) begin
      en = 1'b1; a = mq[0].addr; res = mq[0].res;
    end
    hit = bus.cdb_branch && (bus.cdb_bpb_addr == bus.du_bpb_addr);
    foreach (mq[i]) if (mq[i].addr == bus.du_bpb_addr) hit = 1'b1;
    full  = (mq.size() == QDEPTH);
    stall = !ready || (bus.du_branch && hit);
    return {en, mode, a, res, d, ready, full, m_ovf, stall};
  endfunction

  function automatic logic [12:0] obs_vec();
    logic en, res;
    logic [ADDR-1:0] a;
    en  = bus.bpb_wr_en;
    a   = en ? bus.bpb_wr_addr : '0;
    res = en & bus.bpb_wr_res;
    return {en, bus.bpb_wr_mode, a, res, bus.bpb_wr_data, bus.bpb_ready,
            bus.sched_full, bus.sched_ovf, bus.sched_du_stall};
  endfunction

  function automatic void model_step();
    bit   f, p;
    upd_t u;
    f = (mq.size() == QDEPTH);
    p = (m_cyc > DEPTH) && (mq.size() != 0);
    if (bus.cdb_branch && f) m_ovf = 1'b1;
    if (p) void'(mq.pop_front());
    if (bus.cdb_branch && !f) begin
      u.addr = bus.cdb_bpb_addr;
      u.res  = bus.cdb_branch_res;
      mq.push_back(u);
    end
    if (m_cyc <= DEPTH) m_cyc++;
  endfunction

  task automatic drive(input logic cb, input logic [ADDR-1:0] ca, input logic cr,
                       input logic db, input logic [ADDR-1:0] da);
    bus.cdb_branch     = cb;
    bus.cdb_bpb_addr   = ca;
    bus.cdb_branch_res = cr;
    bus.du_branch      = db;
    bus.du_bpb_addr    = da;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  function automatic logic [ADDR-1:0] rnd_addr();
    return ADDR'($urandom_range(0, DEPTH-1));
  endfunction

  task automatic test_reset();
    logic [12:0] o, e;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, '0, 1'b0, 1'b1, rnd_addr());
      #2;
      o = obs_vec(); e = exp_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL reset c%0d: got %b want %b", c, o, e); end
      tick();
    end
  endtask

  task automatic test_init_sweep();
    logic [12:0] o, e;
    reset = 1'b1;
    for (int c = 0; c < 11; c++) begin
      drive(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), rnd_addr());
      #2;
      o = obs_vec(); e = exp_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL sweep c%0d: got %b want %b", c, o, e); end
      tick();
    end
  endtask

  task automatic test_single_update();
    logic [12:0] o, e;
    logic [ADDR-1:0] du;
    for (int k = 0; k < 2; k++) begin
      du = (k == 0) ? ADDR'(3) : ADDR'(4);
      for (int c = 0; c < 3; c++) begin
        if (c == 0) drive(1'b1, ADDR'(3), 1'b1, 1'b1, du);
        else        drive(1'b0, rnd_addr(), 1'b0, 1'b1, du);
        #2;
        o = obs_vec(); e = exp_vec(); total++;
        if (o !== e) begin bad++; $display("FAIL single du%0d c%0d: got %b want %b", du, c, o, e); end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] o, e;
    for (int c = 0; c < 12; c++) begin
      if (c < 10) drive(1'b1, ADDR'(c % DEPTH), 1'(c & 1), 1'($urandom_range(0, 1)), rnd_addr());
      else        drive(1'b0, '0, 1'b0, 1'b1, rnd_addr());
      #2;
      o = obs_vec(); e = exp_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL b2b c%0d: got %b want %b", c, o, e); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [12:0] o, e;
    for (int c = 0; c < 80; c++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd_addr(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rnd_addr());
      #2;
      o = obs_vec(); e = exp_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL random c%0d: got %b want %b", c, o, e); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [12:0] o, e;
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, (c == 0) ? ADDR'(0) : ADDR'(c + 2), 1'b1, 1'b0, '0);
      else       drive(1'b0, '0, 1'b0, 1'b0, '0);
      #2;
      o = obs_vec(); e = exp_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL midrst fill c%0d: got %b want %b", c, o, e); end
      tick();
    end
    reset = 1'b0;
    model_reset();
    #2;
    o = obs_vec(); e = exp_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL midrst assert: got %b want %b", o, e); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_full_ovf();
    logic [12:0] o, e;
    logic [ADDR-1:0] pa [5];
    pa[0] = ADDR'(1); pa[1] = ADDR'(2); pa[2] = ADDR'(5); pa[3] = ADDR'(6); pa[4] = ADDR'(7);
    for (int c = 0; c < 16; c++) begin
      if (c < 5) drive(1'b1, pa[c], 1'(c & 1), 1'b1, rnd_addr());
      else       drive(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), rnd_addr());
      #2;
      o = obs_vec(); e = exp_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL fullovf c%0d: got %b want %b", c, o, e); end
      tick();
    end
  endtask

  task automatic test_bypass();
    logic [12:0] o, e;
    drive(1'b1, ADDR'(2), 1'b0, 1'b1, ADDR'(2));
    #2;
    total++;
    if (bus.sched_du_stall !== 1'b1) begin
      bad++; $display("FAIL bypass stall: got %b want 1", bus.sched_du_stall);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, ADDR'(2), 1'b1, 1'b1, ADDR'(5));
    #2;
    o = obs_vec(); e = exp_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL bypass miss: got %b want %b", o, e); end
    tick();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    model_reset();
    #1;
    test_reset();
    test_init_sweep();
    test_single_update();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_full_ovf();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
